// File: rtl/mario_motion_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mario_motion_ctrl: per-frame walk / jump / gravity integration of        |
// | Mario's sprite position. Optional MARIO_VARIABLE_JUMP_EN: short hops.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mario_motion_ctrl #(
  parameter int         X_START     = 50,
  parameter int         X_MIN       = 0,
  parameter int         X_MAX       = 639,
  parameter int         SPRITE_W    = 16,
  parameter int         GROUND_Y    = 400,
  parameter int         WALK_SPEED  = 2,
  parameter int         GRAVITY_MAX = 8,
  parameter logic [7:0] JUMP_KEY    = 8'h1A,
  parameter logic [7:0] LEFT_KEY    = 8'h04,
  parameter logic [7:0] RIGHT_KEY   = 8'h07
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycode,
  input  logic [31:0] jump_y_motion,
  output logic        jump_en,
  output logic        hit_ground,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        facing_left,
  output logic        airborne,
  output logic [3:0]  fall_vel
);

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    LAUNCH   = 2'd1,
    RISING   = 2'd2,
    FALLING  = 2'd3
  } state_t;

  localparam logic [9:0]         c_x_start  = 10'(X_START);
  localparam logic [9:0]         c_ground   = 10'(GROUND_Y);
  localparam logic [11:0]        c_ground_w = 12'(GROUND_Y);
  localparam logic signed [11:0] c_ground_s = 12'(GROUND_Y);
  localparam logic signed [11:0] c_x_min    = 12'(X_MIN);
  localparam logic signed [11:0] c_x_right  = 12'(X_MAX - SPRITE_W + 1);
  localparam logic signed [11:0] c_walk     = 12'(WALK_SPEED);
  localparam logic [3:0]         c_grav     = 4'(GRAVITY_MAX);

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_launch_cnt, w_launch_cnt_nxt, w_launch_cnt_inc;
  logic [9:0]         r_pos_x, w_pos_x_nxt;
  logic [9:0]         r_pos_y, w_pos_y_nxt;
  logic [3:0]         r_fall_vel, w_fall_vel_nxt, w_vel_inc;
  logic               r_jump_en, w_jump_en_nxt;
  logic               r_hit_ground, w_hit_ground_nxt;
  logic               r_facing_left, w_facing_left_nxt;
  logic               r_jump_prev;
  logic               w_jump_key, w_left_key, w_right_key;
  logic signed [7:0]  w_motion;
  logic signed [11:0] w_rise_sum, w_x_left, w_x_right;
  logic [11:0]        w_fall_sum;
  logic               w_unused;

  function automatic logic key_hit(input logic [31:0] kc, input logic [7:0] key);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (key != 8'h00 && kc[8*i +: 8] == key) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [9:0] clamp_y(input logic signed [11:0] s);
    if (s < 12'sd0)            return 10'd0;
    else if (s > c_ground_s)   return c_ground;
    else                       return s[9:0];
  endfunction

  assign w_jump_key       = key_hit(keycode, JUMP_KEY);
  assign w_left_key       = key_hit(keycode, LEFT_KEY);
  assign w_right_key      = key_hit(keycode, RIGHT_KEY);
  assign w_motion         = jump_y_motion[7:0];
  assign w_unused         = ^jump_y_motion[31:8];
  assign w_rise_sum       = $signed({2'b00, r_pos_y}) + $signed({{4{w_motion[7]}}, w_motion});
  assign w_vel_inc        = (r_fall_vel >= c_grav) ? c_grav : r_fall_vel + 4'd1;
  assign w_fall_sum       = {2'b00, r_pos_y} + {8'd0, w_vel_inc};
  assign w_x_left         = $signed({2'b00, r_pos_x}) - c_walk;
  assign w_x_right        = $signed({2'b00, r_pos_x}) + c_walk;
  assign w_launch_cnt_inc = r_launch_cnt + 2'd1;

  always_comb begin
    w_state_nxt       = r_state;
    w_launch_cnt_nxt  = r_launch_cnt;
    w_pos_x_nxt       = r_pos_x;
    w_pos_y_nxt       = r_pos_y;
    w_fall_vel_nxt    = r_fall_vel;
    w_jump_en_nxt     = 1'b0;
    w_hit_ground_nxt  = 1'b0;
    w_facing_left_nxt = r_facing_left;

    case (r_state)
      GROUNDED: begin
        w_pos_y_nxt    = c_ground;
        w_fall_vel_nxt = 4'd0;
        if (w_jump_key && !r_jump_prev) begin
          w_jump_en_nxt    = 1'b1;
          w_state_nxt      = LAUNCH;
          w_launch_cnt_nxt = 2'd0;
        end
      end
      LAUNCH: begin
        // Wait out the jump FSM's response latency; give up if it never answers.
        if (w_motion[7]) begin
          w_state_nxt = RISING;
          w_pos_y_nxt = clamp_y(w_rise_sum);
        end else if (w_launch_cnt_inc == 2'd2) begin
          w_state_nxt      = GROUNDED;
          w_launch_cnt_nxt = 2'd0;
        end else begin
          w_launch_cnt_nxt = w_launch_cnt_inc;
        end
      end
      RISING: begin
        if (w_motion[7]) begin
          w_pos_y_nxt = clamp_y(w_rise_sum);
        end else begin
          w_state_nxt    = FALLING;
          w_fall_vel_nxt = 4'd0;
        end
`ifdef MARIO_VARIABLE_JUMP_EN
        if (!w_jump_key) begin
          w_pos_y_nxt    = r_pos_y;
          w_state_nxt    = FALLING;
          w_fall_vel_nxt = 4'd0;
        end
`endif
      end
      FALLING: begin
        if (w_fall_sum >= c_ground_w) begin
          w_pos_y_nxt      = c_ground;
          w_fall_vel_nxt   = 4'd0;
          w_hit_ground_nxt = 1'b1;
          w_state_nxt      = GROUNDED;
        end else begin
          w_pos_y_nxt    = w_fall_sum[9:0];
          w_fall_vel_nxt = w_vel_inc;
        end
      end
      default: w_state_nxt = GROUNDED;
    endcase

    if (w_left_key && !w_right_key) begin
      w_pos_x_nxt       = (w_x_left < c_x_min) ? c_x_min[9:0] : w_x_left[9:0];
      w_facing_left_nxt = 1'b1;
    end else if (w_right_key && !w_left_key) begin
      w_pos_x_nxt       = (w_x_right > c_x_right) ? c_x_right[9:0] : w_x_right[9:0];
      w_facing_left_nxt = 1'b0;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state       <= GROUNDED;
      r_launch_cnt  <= 2'd0;
      r_pos_x       <= c_x_start;
      r_pos_y       <= c_ground;
      r_fall_vel    <= 4'd0;
      r_jump_en     <= 1'b0;
      r_hit_ground  <= 1'b0;
      r_facing_left <= 1'b0;
      r_jump_prev   <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_launch_cnt  <= w_launch_cnt_nxt;
      r_pos_x       <= w_pos_x_nxt;
      r_pos_y       <= w_pos_y_nxt;
      r_fall_vel    <= w_fall_vel_nxt;
      r_jump_en     <= w_jump_en_nxt;
      r_hit_ground  <= w_hit_ground_nxt;
      r_facing_left <= w_facing_left_nxt;
      r_jump_prev   <= w_jump_key;
    end
  end

  assign jump_en     = r_jump_en;
  assign hit_ground  = r_hit_ground;
  assign pos_x       = r_pos_x;
  assign pos_y       = r_pos_y;
  assign fall_vel    = r_fall_vel;
  assign facing_left = r_facing_left;
  assign airborne    = (r_state != GROUNDED);

endmodule
`default_nettype wire

// File: tb/tb_mario_motion_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mario_motion_ctrl: bench for mario_motion_ctrl with a jump FSM model. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mario_motion_ctrl;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [31:0] keycode;
  logic [31:0] jump_y_motion;
  logic        jump_en, hit_ground, facing_left, airborne;
  logic [9:0]  pos_x, pos_y;
  logic [3:0]  fall_vel;

  always #5 frame_clk = ~frame_clk;

  mario_motion_ctrl dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .jump_y_motion (jump_y_motion),
    .jump_en       (jump_en),
    .hit_ground    (hit_ground),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .facing_left   (facing_left),
    .airborne      (airborne),
    .fall_vel      (fall_vel)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Upstream jump FSM: answers jump_en two frames later with a fixed profile.
  int c_prof[20] = '{-12, -12, -12, -12, -10, -10, -10, -10, -8, -8,
                     -6, -6, -4, -4, -2, -2, -2, -2, 0, 0};
  int prof[$];
  int jf_wait = 0;
  bit jf_on = 1'b1;

  // Horizontal reference: position and facing from the walk rules.
  int mx = 50;
  int mf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
    if (Reset || hit_ground) begin
      prof.delete();
      jf_wait = 0;
    end else begin
      if (jf_wait > 0) begin
        jf_wait--;
        if (jf_wait == 0) foreach (c_prof[i]) prof.push_back(c_prof[i]);
      end
      if (jump_en && jf_on) jf_wait = 1;
    end
    jump_y_motion = (prof.size() > 0) ? prof.pop_front() : 0;
  endtask

  // Full jump from an idle ground state; release_after >= 0 drops the key
  // after that many rising frames.
  task automatic run_jump(input string tag, input int release_after, input int apex_req);
    int ey[$];
    int ev[$];
    int y, vel, nrise, miny, hits, ens;
    bit rising, landed;
    y = 400; vel = 0; nrise = 0; rising = 1'b1; landed = 1'b0;
    ey.push_back(400); ev.push_back(0);
    for (int i = 0; i < 20 && rising; i++) begin
      if (c_prof[i] >= 0) rising = 1'b0;
`ifdef MARIO_VARIABLE_JUMP_EN
      else if (release_after >= 0 && nrise == release_after) rising = 1'b0;
`endif
      else begin
        y = (y + c_prof[i] < 0) ? 0 : y + c_prof[i];
        nrise++;
        ey.push_back(y); ev.push_back(0);
      end
    end
    ey.push_back(y); ev.push_back(0);
    for (int k = 0; k < 200 && !landed; k++) begin
      vel = (vel < 8) ? vel + 1 : 8;
      if (y + vel >= 400) begin
        ey.push_back(400); ev.push_back(0);
        landed = 1'b1;
      end else begin
        y += vel;
        ey.push_back(y); ev.push_back(vel);
      end
    end

    keycode = 32'h0;
    step();
    keycode = 32'h0000_001A;
    step();
    chk({tag, "_jump_en"}, jump_en, 1);
    chk({tag, "_airborne0"}, airborne, 1);
    miny = 400; hits = 0; ens = 0;
    for (int k = 0; k < ey.size(); k++) begin
      step();
      chk($sformatf("%s_pos_y[%0d]", tag, k), pos_y, ey[k]);
      chk($sformatf("%s_fall_vel[%0d]", tag, k), fall_vel, ev[k]);
      chk($sformatf("%s_airborne[%0d]", tag, k), airborne, (k == ey.size() - 1) ? 0 : 1);
      hits += int'(hit_ground);
      ens += int'(jump_en);
      if (int'(pos_y) < miny) miny = int'(pos_y);
      if (k == release_after) keycode = 32'h0;
    end
    chk({tag, "_hit_on_land"}, hit_ground, 1);
    chk({tag, "_hit_count"}, hits, 1);
    chk({tag, "_jump_en_extra"}, ens, 0);
    chk({tag, "_apex"}, miny, apex_req);
    for (int k = 0; k < 3; k++) begin
      step();
      chk({tag, "_post_hit"}, hit_ground, 0);
      chk({tag, "_post_jump_en"}, jump_en, 0);
      chk({tag, "_post_pos_y"}, pos_y, 400);
    end
  endtask

  task automatic walk(input string tag, input logic [31:0] kc, input int n);
    bit l, r;
    l = 1'b0; r = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (kc[8*b +: 8] == 8'h04) l = 1'b1;
      if (kc[8*b +: 8] == 8'h07) r = 1'b1;
    end
    keycode = kc;
    for (int i = 0; i < n; i++) begin
      step();
      if (l && !r) begin
        mx = (mx - 2 < 0) ? 0 : mx - 2;
        mf = 1;
      end else if (r && !l) begin
        mx = (mx + 2 > 624) ? 624 : mx + 2;
        mf = 0;
      end
      chk({tag, "_pos_x"}, pos_x, mx);
      chk({tag, "_facing"}, facing_left, mf);
      chk({tag, "_pos_y"}, pos_y, 400);
    end
  endtask

  initial begin
    logic [31:0] kc;
    logic [7:0]  bt;
    Reset = 1'b1;
    keycode = 32'h0000_001A;
    jump_y_motion = 32'h0;
    repeat (3) step();
    chk("rst_pos_x", pos_x, 50);
    chk("rst_pos_y", pos_y, 400);
    chk("rst_airborne", airborne, 0);
    chk("rst_jump_en", jump_en, 0);
    chk("rst_hit", hit_ground, 0);
    chk("rst_fall_vel", fall_vel, 0);
    chk("rst_facing", facing_left, 0);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("held_key_no_jump", jump_en, 0);
      chk("held_key_airborne", airborne, 0);
    end

    run_jump("full", -1, 268);

    jf_on = 1'b0;
    keycode = 32'h0;
    step();
    keycode = 32'h0000_001A;
    step();
    chk("abort_jump_en", jump_en, 1);
    step();
    chk("abort_launch1", airborne, 1);
    chk("abort_pos_y1", pos_y, 400);
    step();
    chk("abort_grounded", airborne, 0);
    chk("abort_hit", hit_ground, 0);
    chk("abort_pos_y2", pos_y, 400);
    step();
    chk("abort_no_rejump", jump_en, 0);
    chk("abort_hit2", hit_ground, 0);
    jf_on = 1'b1;

`ifdef MARIO_VARIABLE_JUMP_EN
    run_jump("short", 4, 352);
`else
    run_jump("short", 4, 268);
`endif

    keycode = 32'h0;
    step();
    keycode = 32'h0000_001A;
    step();
    for (int i = 0; i < 100 && fall_vel != 4'd5; i++) step();
    chk("reach_fall5", fall_vel, 5);
    chk("midfall_airborne", airborne, 1);
    Reset = 1'b1;
    step();
    chk("midrst_pos_y", pos_y, 400);
    chk("midrst_fall_vel", fall_vel, 0);
    chk("midrst_airborne", airborne, 0);
    chk("midrst_pos_x", pos_x, 50);
    chk("midrst_hit", hit_ground, 0);
    chk("midrst_jump_en", jump_en, 0);
    Reset = 1'b0;
    step();
    step();
    chk("midrst_held_key", jump_en, 0);
    chk("midrst_grounded", airborne, 0);

    mx = 50; mf = 0;
    walk("right", 32'h0000_0700, 400);
    walk("left", 32'h0400_0000, 400);
    walk("both", 32'h0004_0007, 20);
    walk("right2", 32'h0700_0000, 30);
    walk("both2", 32'h0700_0004, 20);

    for (int it = 0; it < 300; it++) begin
      kc = 32'h0;
      for (int b = 0; b < 4; b++) begin
        case ($urandom_range(0, 3))
          0: bt = 8'h00;
          1: bt = 8'h04;
          2: bt = 8'h07;
          default: begin
            bt = 8'($urandom_range(8, 255));
            if (bt == 8'h1A) bt = 8'hFF;
          end
        endcase
        kc[8*b +: 8] = bt;
      end
      walk("rand", kc, $urandom_range(1, 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
